// File: rtl/dcache_line_fill.sv
// dcache_line_fill: miss-fill engine that gathers memory beats into one line
// and writes it, with a poison bit, to the data-cache SRAM in a single cycle.
module dcache_line_fill #(
  parameter int BEAT_WIDTH = 64,
  parameter int BEATS = 4,
  parameter int IDX_WIDTH = 10,
  parameter int PADR_WIDTH = 32,
  parameter int TIMEOUT = 1023
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        req_valid,
  output logic                        req_ready,
  input  logic [IDX_WIDTH-1:0]        req_idx,
  input  logic [PADR_WIDTH-1:0]       req_padr,
  output logic                        mem_req_valid,
  input  logic                        mem_req_ready,
  output logic [PADR_WIDTH-1:0]       mem_req_adr,
  input  logic                        mem_resp_valid,
  input  logic [BEAT_WIDTH-1:0]       mem_resp_data,
  input  logic                        mem_resp_err,
  output logic                        wr,
  output logic [IDX_WIDTH-1:0]        wadr,
  output logic [BEATS*BEAT_WIDTH:0]   wdat,
  output logic                        done,
  output logic                        done_err,
  output logic                        busy
);
  localparam int LW = BEATS * BEAT_WIDTH;
  localparam int BW = BEATS > 1 ? $clog2(BEATS) : 1;
  localparam int TW = TIMEOUT > 0 ? $clog2(TIMEOUT + 1) : 1;
  typedef enum logic [1:0] {IDLE, REQ, FILL, WRITE} state_e;
  state_e                state_q, state_d;
  logic [BW-1:0]         beat_q, beat_d;
  logic                  err_q, err_d;
  logic [TW-1:0]         tmo_q, tmo_d;
  logic [LW-1:0]         line_q, line_d;
  logic [IDX_WIDTH-1:0]  idx_q, idx_d, wadr_q, wadr_d;
  logic [PADR_WIDTH-1:0] padr_q, padr_d;
  logic [LW:0]           wdat_q, wdat_d;
  logic                  beat, last, abort;
  assign abort = state_q == FILL && TIMEOUT != 0 && tmo_q == TW'(TIMEOUT);
  assign beat  = state_q == FILL && mem_resp_valid && !abort;
  assign last  = beat && beat_q == BW'(BEATS - 1);
  assign req_ready     = state_q == IDLE;
  assign busy          = state_q != IDLE;
  assign mem_req_valid = state_q == REQ;
  assign mem_req_adr   = padr_q;
  assign wr            = state_q == WRITE;
  assign wadr          = wadr_q;
  assign wdat          = wdat_q;
  assign done          = wr || abort;
  assign done_err      = abort || (wr && err_q);
  // SRAM-facing wadr/wdat are captured only on the final beat so they hold between writes
  always_comb begin
    state_d = state_q;
    beat_d  = beat_q;
    err_d   = err_q;
    tmo_d   = tmo_q;
    line_d  = line_q;
    idx_d   = idx_q;
    padr_d  = padr_q;
    wadr_d  = wadr_q;
    wdat_d  = wdat_q;
    if (state_q == IDLE && req_valid) begin
      state_d = REQ;
      idx_d   = req_idx;
      padr_d  = req_padr;
      beat_d  = '0;
      err_d   = 1'b0;
      tmo_d   = '0;
      line_d  = '0;
    end
    if (state_q == REQ && mem_req_ready) state_d = FILL;
    if (state_q == FILL) tmo_d = beat ? '0 : tmo_q + 1'b1;
    if (beat) begin
      line_d[int'(beat_q) * BEAT_WIDTH +: BEAT_WIDTH] = mem_resp_data;
      err_d  = err_q | mem_resp_err;
      beat_d = beat_q + 1'b1;
    end
    if (last) begin
      state_d = WRITE;
      wadr_d  = idx_q;
      wdat_d  = {err_d, line_d};
    end
    if (abort || state_q == WRITE) state_d = IDLE;
  end
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      beat_q  <= '0;
      err_q   <= 1'b0;
      tmo_q   <= '0;
      line_q  <= '0;
      idx_q   <= '0;
      padr_q  <= '0;
      wadr_q  <= '0;
      wdat_q  <= '0;
    end else begin
      state_q <= state_d;
      beat_q  <= beat_d;
      err_q   <= err_d;
      tmo_q   <= tmo_d;
      line_q  <= line_d;
      idx_q   <= idx_d;
      padr_q  <= padr_d;
      wadr_q  <= wadr_d;
      wdat_q  <= wdat_d;
    end
  end
endmodule

// File: tb/tb_dcache_line_fill.sv
// tb_dcache_line_fill: randomized fills checked against a line-level model of
// the expected SRAM writes, completion pulses and handshake timing.
module tb_dcache_line_fill;
  localparam int TMO = 16;
  logic clk = 0, rst = 1;
  logic req_valid = 0, req_ready;
  logic [9:0] req_idx = 0;
  logic [31:0] req_padr = 0;
  logic mem_req_valid, mem_req_ready = 0;
  logic [31:0] mem_req_adr;
  logic mem_resp_valid = 0, mem_resp_err = 0;
  logic [63:0] mem_resp_data = 0;
  logic wr, done, done_err, busy;
  logic [9:0] wadr;
  logic [256:0] wdat;
  int checks = 0, failures = 0, cyc = 0, viol = 0, unstable = 0;
  logic [31:0] last_adr = 0, pa = 0;
  logic pv = 0, pr = 0;
  logic [9:0] wq_adr[$];
  logic [256:0] wq_dat[$];
  int wq_cyc[$], dq_cyc[$], acc_q[$];
  logic dq_err[$];
  logic [63:0] bd[4];
  logic be[4];

  dcache_line_fill #(.TIMEOUT(TMO)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
    .req_idx(req_idx), .req_padr(req_padr), .mem_req_valid(mem_req_valid),
    .mem_req_ready(mem_req_ready), .mem_req_adr(mem_req_adr),
    .mem_resp_valid(mem_resp_valid), .mem_resp_data(mem_resp_data),
    .mem_resp_err(mem_resp_err), .wr(wr), .wadr(wadr), .wdat(wdat),
    .done(done), .done_err(done_err), .busy(busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (wr) begin wq_adr.push_back(wadr); wq_dat.push_back(wdat); wq_cyc.push_back(cyc); end
    if (done) begin dq_err.push_back(done_err); dq_cyc.push_back(cyc); end
    if ((done_err && !done) || (wr && !done)) viol++;
    if (req_valid && req_ready && rst) acc_q.push_back(cyc);
    if (mem_req_valid) last_adr = mem_req_adr;
    if (pv && !pr && (mem_req_valid !== 1'b1 || mem_req_adr !== pa)) unstable++;
    pv = mem_req_valid & rst;
    pr = mem_req_ready;
    pa = mem_req_adr;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_q();
    wq_adr.delete(); wq_dat.delete(); wq_cyc.delete();
    dq_err.delete(); dq_cyc.delete(); acc_q.delete();
  endtask

  task automatic rand_beats();
    for (int b = 0; b < 4; b++) begin bd[b] = {$urandom, $urandom}; be[b] = 1'b0; end
  endtask

  function automatic logic [256:0] model_line();
    logic [255:0] d;
    logic e;
    e = 1'b0;
    for (int b = 0; b < 4; b++) begin d[b*64 +: 64] = bd[b]; e = e | be[b]; end
    return {e, d};
  endfunction

  task automatic fill(input logic [9:0] idx, input logic [31:0] padr, input int stall,
                      input int gap, input int nb, output int acc, output int lastb);
    req_valid = 1; req_idx = idx; req_padr = padr;
    for (int t = 0; t < 50 && !req_ready; t++) tick();
    acc = cyc;
    lastb = cyc;
    tick();
    req_valid = 0;
    for (int s = 0; s < stall; s++) tick();
    mem_req_ready = 1;
    tick();
    mem_req_ready = 0;
    for (int b = 0; b < nb; b++) begin
      for (int g = 0; g < gap; g++) tick();
      mem_resp_valid = 1; mem_resp_data = bd[b]; mem_resp_err = be[b];
      lastb = cyc;
      tick();
      mem_resp_valid = 0; mem_resp_data = {$urandom, $urandom}; mem_resp_err = 0;
    end
  endtask

  task automatic wait_done(input int n);
    for (int t = 0; t < 40 && dq_cyc.size() < n; t++) tick();
  endtask

  task automatic test_reset();
    rst = 1; #2 rst = 0;
    tick(); tick();
    checks++; if (req_ready !== 1'b1 || busy !== 1'b0) begin failures++;
      $display("FAIL reset_ctrl: req_ready=%b busy=%b, expected 1 0", req_ready, busy); end
    checks++; if (mem_req_valid !== 1'b0 || mem_req_adr !== 32'h0) begin failures++;
      $display("FAIL reset_mem: valid=%b adr=%h, expected 0 0", mem_req_valid, mem_req_adr); end
    checks++; if (wr !== 1'b0 || wadr !== 10'h0 || wdat !== 257'h0) begin failures++;
      $display("FAIL reset_sram: wr=%b wadr=%h wdat=%h, expected zeros", wr, wadr, wdat); end
    checks++; if (done !== 1'b0 || done_err !== 1'b0) begin failures++;
      $display("FAIL reset_done: done=%b done_err=%b, expected 0 0", done, done_err); end
    rst = 1;
    tick();
  endtask

  task automatic test_basic();
    int acc, lb;
    logic [256:0] exp_line;
    clear_q();
    bd[0] = 64'h1111_1111_1111_1111; bd[1] = 64'h2222_2222_2222_2222;
    bd[2] = 64'h3333_3333_3333_3333; bd[3] = 64'h4444_4444_4444_4444;
    for (int b = 0; b < 4; b++) be[b] = 1'b0;
    exp_line = model_line();
    fill(10'h2A5, 32'h0001_2340, 0, 0, 4, acc, lb);
    wait_done(1);
    checks++; if (last_adr !== 32'h0001_2340) begin failures++;
      $display("FAIL basic_adr: got %h expected 00012340", last_adr); end
    checks++; if (wq_adr.size() != 1 || dq_cyc.size() != 1) begin failures++;
      $display("FAIL basic_count: wr=%0d done=%0d expected 1 1", wq_adr.size(), dq_cyc.size()); end
    checks++; if (wq_adr.size() == 0 || wq_adr[0] !== 10'h2A5) begin failures++;
      $display("FAIL basic_wadr: got %h expected 2a5", wq_adr.size() ? wq_adr[0] : 10'hx); end
    checks++; if (wq_dat.size() == 0 || wq_dat[0] !== exp_line) begin failures++;
      $display("FAIL basic_wdat: got %h expected %h", wq_dat.size() ? wq_dat[0] : 257'hx, exp_line); end
    checks++; if (wq_cyc.size() == 0 || wq_cyc[0] != acc + 6 || dq_cyc.size() == 0 || dq_cyc[0] != acc + 6) begin failures++;
      $display("FAIL basic_latency: wr/done cycle offset %0d expected 6", wq_cyc.size() ? wq_cyc[0] - acc : -1); end
    checks++; if (dq_err.size() == 0 || dq_err[0] !== 1'b0) begin failures++;
      $display("FAIL basic_done_err: got %b expected 0", dq_err.size() ? dq_err[0] : 1'bx); end
    checks++; if (req_ready !== 1'b1 || cyc != acc + 7) begin failures++;
      $display("FAIL basic_ready: req_ready=%b at offset %0d expected 1 at 7", req_ready, cyc - acc); end
  endtask

  task automatic test_stall();
    int acc, lb;
    logic [9:0] idx;
    logic [31:0] padr;
    logic [256:0] exp_line;
    clear_q();
    unstable = 0;
    rand_beats();
    exp_line = model_line();
    idx = 10'($urandom); padr = $urandom & 32'hFFFF_FFE0;
    fill(idx, padr, 5, 2, 4, acc, lb);
    wait_done(1);
    repeat (4) tick();
    checks++; if (unstable != 0 || last_adr !== padr) begin failures++;
      $display("FAIL stall_req_stable: changes=%0d adr=%h expected 0 %h", unstable, last_adr, padr); end
    checks++; if (wq_adr.size() != 1) begin failures++;
      $display("FAIL stall_wr_count: got %0d expected 1", wq_adr.size()); end
    checks++; if (wq_dat.size() == 0 || wq_dat[0] !== exp_line || wq_adr[0] !== idx) begin failures++;
      $display("FAIL stall_line: wdat=%h wadr=%h expected %h %h", wq_dat.size() ? wq_dat[0] : 257'hx,
               wq_adr.size() ? wq_adr[0] : 10'hx, exp_line, idx); end
    checks++; if (wq_cyc.size() == 0 || wq_cyc[0] != lb + 1) begin failures++;
      $display("FAIL stall_wr_timing: offset after last beat %0d expected 1", wq_cyc.size() ? wq_cyc[0] - lb : -1); end
  endtask

  task automatic test_error();
    int acc, lb;
    logic [256:0] exp_line;
    clear_q();
    rand_beats();
    be[2] = 1'b1;
    exp_line = model_line();
    fill(10'h155, 32'hABCD_0000, 1, 1, 4, acc, lb);
    wait_done(1);
    checks++; if (wq_dat.size() == 0 || wq_dat[0][256] !== 1'b1) begin failures++;
      $display("FAIL err_poison: got %b expected 1", wq_dat.size() ? wq_dat[0][256] : 1'bx); end
    checks++; if (wq_dat.size() == 0 || wq_dat[0] !== exp_line) begin failures++;
      $display("FAIL err_data: got %h expected %h", wq_dat.size() ? wq_dat[0] : 257'hx, exp_line); end
    checks++; if (dq_err.size() == 0 || dq_err[0] !== 1'b1) begin failures++;
      $display("FAIL err_done_err: got %b expected 1", dq_err.size() ? dq_err[0] : 1'bx); end
  endtask

  task automatic test_random();
    int acc, lb;
    logic [9:0] idx;
    logic [256:0] exp_line;
    for (int n = 0; n < 5; n++) begin
      clear_q();
      rand_beats();
      for (int b = 0; b < 4; b++) be[b] = ($urandom % 4) == 0;
      exp_line = model_line();
      idx = 10'($urandom);
      fill(idx, $urandom & 32'hFFFF_FFE0, $urandom_range(0, 3), $urandom_range(0, 3), 4, acc, lb);
      wait_done(1);
      checks++; if (wq_dat.size() != 1 || wq_dat[0] !== exp_line || wq_adr[0] !== idx ||
                    dq_err[0] !== exp_line[256]) begin failures++;
        $display("FAIL random_fill%0d: wdat=%h wadr=%h expected %h %h", n,
                 wq_dat.size() ? wq_dat[0] : 257'hx, wq_adr.size() ? wq_adr[0] : 10'hx, exp_line, idx); end
    end
  endtask

  task automatic test_timeout();
    int acc, lb;
    logic [9:0] idx;
    logic [256:0] exp_line;
    clear_q();
    rand_beats();
    fill(10'h0F0, 32'h5555_0000, 0, 0, 2, acc, lb);
    wait_done(1);
    checks++; if (dq_cyc.size() != 1 || dq_cyc[0] != lb + 1 + TMO) begin failures++;
      $display("FAIL timeout_cycle: done offset %0d expected %0d", dq_cyc.size() ? dq_cyc[0] - lb : -1, 1 + TMO); end
    checks++; if (dq_err.size() == 0 || dq_err[0] !== 1'b1 || wq_adr.size() != 0) begin failures++;
      $display("FAIL timeout_abort: done_err=%b writes=%0d expected 1 0", dq_err.size() ? dq_err[0] : 1'bx, wq_adr.size()); end
    checks++; if (req_ready !== 1'b1 || busy !== 1'b0) begin failures++;
      $display("FAIL timeout_idle: req_ready=%b busy=%b expected 1 0", req_ready, busy); end
    clear_q();
    rand_beats();
    exp_line = model_line();
    idx = 10'($urandom);
    fill(idx, 32'h5555_0040, 0, 0, 4, acc, lb);
    wait_done(1);
    checks++; if (wq_dat.size() != 1 || wq_dat[0] !== exp_line || dq_err[0] !== 1'b0) begin failures++;
      $display("FAIL timeout_recover: wdat=%h expected %h", wq_dat.size() ? wq_dat[0] : 257'hx, exp_line); end
  endtask

  task automatic test_reset_mid();
    int acc, lb;
    logic [9:0] idx;
    logic [256:0] exp_line;
    clear_q();
    rand_beats();
    fill(10'h3C3, 32'h7777_0000, 0, 0, 2, acc, lb);
    #2 rst = 0;
    #1;
    checks++; if (busy !== 1'b0 || req_ready !== 1'b1 || wr !== 1'b0 || done !== 1'b0 ||
                  mem_req_adr !== 32'h0 || wadr !== 10'h0 || wdat !== 257'h0) begin failures++;
      $display("FAIL midreset_async: busy=%b ready=%b wr=%b done=%b adr=%h wadr=%h expected reset values",
               busy, req_ready, wr, done, mem_req_adr, wadr); end
    tick(); tick();
    rst = 1;
    tick();
    checks++; if (wq_adr.size() != 0 || dq_cyc.size() != 0) begin failures++;
      $display("FAIL midreset_quiet: writes=%0d dones=%0d expected 0 0", wq_adr.size(), dq_cyc.size()); end
    rand_beats();
    exp_line = model_line();
    idx = 10'($urandom);
    fill(idx, 32'h7777_0020, 0, 0, 4, acc, lb);
    wait_done(1);
    checks++; if (wq_dat.size() != 1 || wq_dat[0] !== exp_line || wq_adr[0] !== idx) begin failures++;
      $display("FAIL midreset_refill: wdat=%h expected %h", wq_dat.size() ? wq_dat[0] : 257'hx, exp_line); end
  endtask

  task automatic test_back_to_back();
    logic [63:0] b1[4], b2[4];
    logic [256:0] e1, e2;
    int c0;
    clear_q();
    rand_beats(); b1 = bd; e1 = model_line();
    rand_beats(); b2 = bd; e2 = model_line();
    mem_req_ready = 1;
    c0 = cyc;
    for (int c = 0; c < 16; c++) begin
      req_valid = c < 8;
      req_idx = c < 1 ? 10'h011 : 10'h322;
      req_padr = c < 1 ? 32'h1000_0000 : 32'h2000_0000;
      mem_resp_valid = 1;
      mem_resp_err = 1;
      mem_resp_data = {$urandom, $urandom};
      if (c >= 2 && c <= 5) begin mem_resp_data = b1[c-2]; mem_resp_err = 0; end
      if (c >= 9 && c <= 12) begin mem_resp_data = b2[c-9]; mem_resp_err = 0; end
      tick();
    end
    mem_resp_valid = 0; mem_resp_err = 0; mem_req_ready = 0; req_valid = 0;
    tick();
    checks++; if (acc_q.size() != 2 || acc_q[0] != c0 || acc_q[1] != c0 + 7) begin failures++;
      $display("FAIL b2b_accept: accepts=%0d second offset %0d expected 2 at 7", acc_q.size(),
               acc_q.size() > 1 ? acc_q[1] - c0 : -1); end
    checks++; if (wq_dat.size() != 2 || wq_dat[0] !== e1 || wq_adr[0] !== 10'h011) begin failures++;
      $display("FAIL b2b_first: wdat=%h expected %h", wq_dat.size() ? wq_dat[0] : 257'hx, e1); end
    checks++; if (wq_dat.size() != 2 || wq_dat[1] !== e2 || wq_adr[1] !== 10'h322 || wq_cyc[1] != c0 + 13) begin failures++;
      $display("FAIL b2b_second: wdat=%h expected %h", wq_dat.size() > 1 ? wq_dat[1] : 257'hx, e2); end
    checks++; if (dq_err.size() != 2 || dq_err[0] !== 1'b0 || dq_err[1] !== 1'b0) begin failures++;
      $display("FAIL b2b_done_err: dones=%0d expected 2 clean", dq_err.size()); end
    checks++; if (viol != 0) begin failures++;
      $display("FAIL qualifier: done_err/wr without done seen %0d times, expected 0", viol); end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_stall();
    test_error();
    test_random();
    test_timeout();
    test_reset_mid();
    test_back_to_back();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
